// File: rtl/avmm_pkg.sv
// rtl/avmm_pkg.sv - shared response codes and counter width for the Avalon-MM RAM slave
package avmm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for the largest target count (15 wait states).
    localparam int CNT_W = 5;

endpackage

// File: rtl/sp_ram_be.sv
// rtl/sp_ram_be.sv - byte-enabled single-port RAM with reset output pipeline
module sp_ram_be #(
    parameter int    ADDR_W       = 12,
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 4096,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] pipe_q [READ_LATENCY];

    // Array read guarded so addresses past the end of a non-power-of-two depth return zero.
    always_comb begin
        rd_raw = '0;
        if ({1'b0, addr_i} < DEPTH_L) begin
            rd_raw = mem[addr_i];
        end
    end

    // Byte-lane writes; the array itself carries no reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Output pipeline, READ_LATENCY stages deep, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_raw;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rdata_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/avmm_ram_slave.sv
// rtl/avmm_ram_slave.sv - Avalon-MM slave around a byte-enabled RAM with wait states and error responses
module avmm_ram_slave
    import avmm_pkg::*;
#(
    parameter int    ADDR_W       = 12,
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 4096,
    parameter int    READ_LATENCY = 1,
    parameter int    WAIT_CYCLES  = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   ctrl_address,
    input  logic                ctrl_read,
    input  logic                ctrl_write,
    input  logic [DATA_W/8-1:0] ctrl_byteenable,
    input  logic [DATA_W-1:0]   ctrl_writedata,
    output logic [DATA_W-1:0]   ctrl_readdata,
    output logic [1:0]          ctrl_response,
    output logic                ctrl_waitrequest,
    input  logic                wp
);

    localparam int NB = DATA_W / 8;
    localparam int N_RD_I = (WAIT_CYCLES > READ_LATENCY) ? WAIT_CYCLES : READ_LATENCY;
    localparam logic [CNT_W-1:0] N_WR = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] N_RD = CNT_W'(N_RD_I);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_tgt;
    logic             req;
    logic             accept;
    logic             in_range;
    logic             wr_only;
    logic [NB-1:0]    ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign req      = ctrl_read | ctrl_write;
    assign n_tgt    = ctrl_read ? N_RD : N_WR;
    assign in_range = ({1'b0, ctrl_address} < DEPTH_L);
    assign wr_only  = ctrl_write & ~ctrl_read;

    // Acceptance: zero-wait writes complete straight out of IDLE, everything else at cnt==N in BUSY.
    always_comb begin
        accept = 1'b0;
        if (rst_n && req) begin
            if (state_q == ST_IDLE) begin
                accept = (n_tgt == '0);
            end else begin
                accept = (cnt_q == n_tgt);
            end
        end
    end

    assign ctrl_waitrequest = ~rst_n | (req & ~accept);

    // Next-state logic: count up while stalled, fall back to IDLE on accept or when the master withdraws.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!req || accept) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Exactly one write pulse per transfer, only in the accept cycle and only when allowed.
    assign ram_we = {NB{accept & wr_only & in_range & ~wp}} & ctrl_byteenable;

    // Response mux: decode error outranks write protection.
    always_comb begin
        ctrl_response = RESP_OKAY;
        if (accept) begin
            if (!in_range) begin
                ctrl_response = RESP_DECERR;
            end else if (wr_only && wp) begin
                ctrl_response = RESP_SLVERR;
            end
        end
    end

    // Out-of-range reads return zero; otherwise the RAM output passes straight through.
    always_comb begin
        ctrl_readdata = ram_rdata;
        if (accept && ctrl_read && !in_range) begin
            ctrl_readdata = '0;
        end
    end

    sp_ram_be #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .INIT_FILE    (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .addr_i  (ctrl_address),
        .we_i    (ram_we),
        .wdata_i (ctrl_writedata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_avmm_ram_slave.sv
// tb/tb_avmm_ram_slave.sv - scoreboard bench for avmm_ram_slave across two configurations
module tb_avmm_ram_slave;

    localparam int D0_DEPTH = 3000;
    localparam int D0_RL    = 1;
    localparam int D0_WAIT  = 0;
    localparam int D1_DEPTH = 4096;
    localparam int D1_RL    = 2;
    localparam int D1_WAIT  = 3;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          waits;
        bit          is_read;
    } exp_t;

    logic        clk;
    logic        rst_n;
    bit          sel;
    logic [11:0] addr;
    logic        rd, wr, wp;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic [31:0] rdata0, rdata1, rdata;
    logic [1:0]  resp0, resp1, resp;
    logic        wait0, wait1, waitreq;

    exp_t        exp_q[$];
    logic [31:0] model[int];
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    avmm_ram_slave #(
        .ADDR_W(12), .DATA_W(32), .DEPTH(D0_DEPTH),
        .READ_LATENCY(D0_RL), .WAIT_CYCLES(D0_WAIT), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ctrl_address(addr),
        .ctrl_read(rd & !sel), .ctrl_write(wr & !sel),
        .ctrl_byteenable(be), .ctrl_writedata(wdata),
        .ctrl_readdata(rdata0), .ctrl_response(resp0),
        .ctrl_waitrequest(wait0), .wp(wp)
    );

    avmm_ram_slave #(
        .ADDR_W(12), .DATA_W(32), .DEPTH(D1_DEPTH),
        .READ_LATENCY(D1_RL), .WAIT_CYCLES(D1_WAIT), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ctrl_address(addr),
        .ctrl_read(rd & sel), .ctrl_write(wr & sel),
        .ctrl_byteenable(be), .ctrl_writedata(wdata),
        .ctrl_readdata(rdata1), .ctrl_response(resp1),
        .ctrl_waitrequest(wait1), .wp(wp)
    );

    assign rdata   = sel ? rdata1 : rdata0;
    assign resp    = sel ? resp1  : resp0;
    assign waitreq = sel ? wait1  : wait0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One Avalon transfer: expected result is queued at drive time and compared at acceptance.
    task automatic xfer(input string tag, input bit r, input bit w, input int a,
                        input logic [3:0] b, input logic [31:0] d);
        exp_t e, got_e;
        int   key, depth, wt, rl, waits;
        bit   in_range, done;
        depth    = sel ? D1_DEPTH : D0_DEPTH;
        wt       = sel ? D1_WAIT  : D0_WAIT;
        rl       = sel ? D1_RL    : D0_RL;
        key      = (sel ? 65536 : 0) + a;
        in_range = (a < depth);
        if (r) begin
            e.is_read = 1'b1;
            e.waits   = (wt > rl) ? wt : rl;
            e.data    = in_range ? model[key] : 32'h0;
            e.resp    = in_range ? 2'b00 : 2'b11;
        end else begin
            e.is_read = 1'b0;
            e.waits   = wt;
            e.data    = 32'h0;
            e.resp    = !in_range ? 2'b11 : (wp ? 2'b10 : 2'b00);
            if (e.resp == 2'b00) begin
                logic [31:0] m;
                m = model.exists(key) ? model[key] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) m[i*8 +: 8] = d[i*8 +: 8];
                end
                model[key] = m;
            end
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        addr  = 12'(a);
        rd    = r;
        wr    = w;
        be    = b;
        wdata = d;
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!waitreq) done = 1'b1;
            else waits++;
        end
        got_e = exp_q.pop_front();
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout got=stalled exp=accept", tag);
        end else begin
            check_val({tag, "_waits"}, 32'(waits), 32'(got_e.waits));
            check_val({tag, "_resp"}, {30'h0, resp}, {30'h0, got_e.resp});
            if (got_e.is_read) check_val({tag, "_data"}, rdata, got_e.data);
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        int waits;
        bit done;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        sel   = 1'b0;
        wp    = 1'b0;
        rd    = 1'b0;
        be    = 4'hF;
        wdata = 32'h0;
        // Zero-wait write to an out-of-range address would accept if reset did not force a stall.
        addr  = 12'd3000;
        wr    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wait0", {31'h0, wait0}, 32'h1);
        check_val("rst_resp0", {30'h0, resp0}, 32'h0);
        check_val("rst_rdata0", rdata0, 32'h0);
        check_val("rst_wait1", {31'h0, wait1}, 32'h1);
        check_val("rst_rdata1", rdata1, 32'h0);
        wr = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Configuration 0: no wait states, read latency 1, depth 3000.
        sel = 1'b0;
        xfer("wr_deadbeef", 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        xfer("rd_deadbeef", 1, 0, 12'h010, 4'hF, 32'h0);
        xfer("wr_pre",      0, 1, 12'h011, 4'hF, 32'h11223344);
        xfer("wr_lanes",    0, 1, 12'h011, 4'b0101, 32'hAABBCCDD);
        xfer("rd_lanes",    1, 0, 12'h011, 4'hF, 32'h0);
        check_val("lanes_model", model[12'h011], 32'h11BB33DD);
        xfer("wr_be0",      0, 1, 12'h011, 4'h0, 32'hFFFFFFFF);
        xfer("rd_be0",      1, 0, 12'h011, 4'hF, 32'h0);
        xfer("wr_oor",      0, 1, 3000, 4'hF, 32'h12121212);
        xfer("rd_oor",      1, 0, 3000, 4'hF, 32'h0);
        xfer("wr_oor_top",  0, 1, 4095, 4'hF, 32'h34343434);
        xfer("wr_last",     0, 1, 2999, 4'hF, 32'h5A5A5A5A);
        xfer("rd_last",     1, 0, 2999, 4'hF, 32'h0);
        xfer("wr_5",        0, 1, 5, 4'hF, 32'h0A0B0C0D);
        wp = 1'b1;
        xfer("wr_5_wp",     0, 1, 5, 4'hF, 32'hFFFFFFFF);
        xfer("wr_oor_wp",   0, 1, 3001, 4'hF, 32'hFFFFFFFF);
        wp = 1'b0;
        xfer("rd_5",        1, 0, 5, 4'hF, 32'h0);
        xfer("rdwr_both",   1, 1, 12'h010, 4'hF, 32'h0);
        xfer("rd_after_rw", 1, 0, 12'h010, 4'hF, 32'h0);

        // Configuration 1: three wait states, read latency 2.
        sel = 1'b1;
        xfer("wr_w3",   0, 1, 12'h020, 4'hF, 32'h01020304);
        xfer("rd_w3",   1, 0, 12'h020, 4'hF, 32'h0);
        xfer("wr_40",   0, 1, 12'h040, 4'hF, 32'h12345678);

        // Reset at cnt=2 with the write held; it must finish afresh after release.
        @(posedge clk);
        #1;
        addr = 12'h040; wr = 1'b1; be = 4'hF; wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check_val("pre_rst_wait", {31'h0, waitreq}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_wait", {31'h0, waitreq}, 32'h1);
        check_val("mid_rst_resp", {30'h0, resp}, 32'h0);
        check_val("mid_rst_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!waitreq) done = 1'b1;
            else waits++;
        end
        check_val("post_rst_accepted", {31'h0, done}, 32'h1);
        check_val("post_rst_waits", 32'(waits), 32'(D1_WAIT));
        model[65536 + 12'h040] = 32'hCAFEF00D;
        @(posedge clk);
        #1 wr = 1'b0;
        xfer("rd_post_rst", 1, 0, 12'h040, 4'hF, 32'h0);

        // Reset at cnt=2 and the master gives up: memory must keep its old value.
        @(posedge clk);
        #1;
        addr = 12'h040; wr = 1'b1; be = 4'hF; wdata = 32'h0BADBEEF;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        xfer("rd_rst_abort", 1, 0, 12'h040, 4'hF, 32'h0);

        // Master withdraws mid-BUSY: FSM idles and the next read gets the full wait.
        @(posedge clk);
        #1;
        addr = 12'h040; wr = 1'b1; be = 4'hF; wdata = 32'h55555555;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 wr = 1'b0;
        @(negedge clk);
        check_val("abort_idle_wait", {31'h0, waitreq}, 32'h0);
        xfer("rd_abort", 1, 0, 12'h040, 4'hF, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
